// File: rtl/sensor_pattern_gen_if.sv
// Command/status bundle between a car-pass command source and the sensor pattern generator.
interface sensor_pattern_gen_if #(
  parameter int unsigned HOLD_W = 20
) ();
  logic              cmd_valid;
  logic              cmd_dir;
  logic [HOLD_W-1:0] hold;
  logic              cmd_ready;
  logic              psensor;
  logic              ssensor;
  logic              busy;
  logic              done;
  logic [3:0]        evt_count;

  modport master (
    output cmd_valid, cmd_dir, hold,
    input  cmd_ready, psensor, ssensor, busy, done, evt_count
  );

  modport slave (
    input  cmd_valid, cmd_dir, hold,
    output cmd_ready, psensor, ssensor, busy, done, evt_count
  );
endinterface

// File: rtl/sensor_pattern_gen.sv
// Generates the two-sensor waveform of one car entering or leaving a lot, per accepted command.
// Define SENSOR_GEN_BOUNCE_EN to inject contact-bounce glitches on each changing sensor.
module sensor_pattern_gen #(
  parameter int unsigned HOLD_W     = 20,
  parameter int unsigned BOUNCE_N   = 3,
  parameter int unsigned BOUNCE_LEN = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sensor_pattern_gen_if.slave gen_if
);

  if (HOLD_W == 0 || BOUNCE_N == 0 || BOUNCE_LEN == 0) begin : g_bad_cfg
    $error("sensor_pattern_gen: HOLD_W, BOUNCE_N and BOUNCE_LEN must be non-zero");
  end

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dir_q, dir_d;
  logic [3:0]        evt_q, evt_d;
  logic              psensor_q, psensor_d;
  logic              ssensor_q, ssensor_d;
  logic              phase_end;
  logic              in_phase;
  logic              glitch;

  assign phase_end = (cnt_q == hold_q - HOLD_W'(1));
  assign in_phase  = state_d inside {StPh1, StPh2, StPh3, StGap};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    evt_d   = evt_q;
    unique case (state_q)
      StIdle: begin
        if (gen_if.cmd_valid) begin
          state_d = StPh1;
          cnt_d   = '0;
          dir_d   = gen_if.cmd_dir;
          hold_d  = (gen_if.hold == '0) ? HOLD_W'(1) : gen_if.hold;
        end
      end
      StPh1, StPh2, StPh3, StGap: begin
        if (phase_end) begin
          cnt_d = '0;
          case (state_q)
            StPh1:   state_d = StPh2;
            StPh2:   state_d = StPh3;
            StPh3:   state_d = StGap;
            default: state_d = StDone;
          endcase
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!dir_q) begin
          if (evt_q != 4'd15) evt_d = evt_q + 4'd1;
        end else begin
          if (evt_q != 4'd0) evt_d = evt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SENSOR_GEN_BOUNCE_EN
  localparam int unsigned SlotMax = 2 * BOUNCE_N;
  localparam int unsigned SlotW   = $clog2(SlotMax + 1);
  localparam int unsigned LenW    = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;

  logic [SlotW-1:0] bslot_q, bslot_d;
  logic [LenW-1:0]  blen_q, blen_d;

  // Slot index counts BOUNCE_LEN-cycle runs since phase entry; odd slots show the old level.
  always_comb begin
    bslot_d = bslot_q;
    blen_d  = blen_q;
    if (state_d != state_q) begin
      bslot_d = '0;
      blen_d  = '0;
    end else if (bslot_q < SlotW'(SlotMax)) begin
      if (blen_q == LenW'(BOUNCE_LEN - 1)) begin
        blen_d  = '0;
        bslot_d = bslot_q + SlotW'(1);
      end else begin
        blen_d = blen_q + LenW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bslot_q <= '0;
      blen_q  <= '0;
    end else begin
      bslot_q <= bslot_d;
      blen_q  <= blen_d;
    end
  end

  assign glitch = in_phase & (bslot_d < SlotW'(SlotMax)) & bslot_d[0];
`else
  assign glitch = 1'b0;
`endif

  // Lead sensor sees the car first, trail sensor second; direction maps them onto p/s.
  logic lead_lvl, trail_lvl, lead_chg;
  always_comb begin
    lead_chg  = state_d inside {StPh1, StPh3};
    lead_lvl  = (state_d inside {StPh1, StPh2}) ^ (glitch & lead_chg);
    trail_lvl = (state_d inside {StPh2, StPh3}) ^ (glitch & ~lead_chg);
    psensor_d = dir_d ? trail_lvl : lead_lvl;
    ssensor_d = dir_d ? lead_lvl : trail_lvl;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hold_q    <= '0;
      dir_q     <= 1'b0;
      evt_q     <= '0;
      psensor_q <= 1'b0;
      ssensor_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      evt_q     <= evt_d;
      psensor_q <= psensor_d;
      ssensor_q <= ssensor_d;
    end
  end

  assign gen_if.cmd_ready = (state_q == StIdle);
  assign gen_if.busy      = (state_q != StIdle);
  assign gen_if.done      = (state_q == StDone);
  assign gen_if.psensor   = psensor_q;
  assign gen_if.ssensor   = ssensor_q;
  assign gen_if.evt_count = evt_q;

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Directed bench for sensor_pattern_gen: entry/exit patterns, hold=0, saturation, resets.
module tb_sensor_pattern_gen;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   exp_evt = 0;

  always #5 clk = ~clk;

  sensor_pattern_gen_if #(.HOLD_W(20)) bus ();

  sensor_pattern_gen #(
    .HOLD_W    (20),
    .BOUNCE_N  (3),
    .BOUNCE_LEN(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .gen_if(bus)
  );

  // Clean {p,s} levels of phase ph (0..2 = PH1..PH3, else idle-like).
  function automatic logic [1:0] lvl(input logic dir, input int ph);
    case (ph)
      0:       return dir ? 2'b01 : 2'b10;
      1:       return 2'b11;
      2:       return dir ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_ps(input logic dir, input int ph, input int idx);
    logic [1:0] cur, prev;
    cur  = lvl(dir, ph);
    prev = (ph == 0) ? 2'b00 : lvl(dir, ph - 1);
`ifdef SENSOR_GEN_BOUNCE_EN
    if (ph < 4 && idx < 24 && ((idx / 4) % 2) == 1) cur = prev;
`endif
    if (idx < 0) cur = 2'b00;
    return cur;
  endfunction

  task automatic issue(input logic dir, input int h);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.hold      = 20'(h);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [8:0] got;
    #2 rst_n = 1'b0;
    #1;
    got = {bus.psensor, bus.ssensor, bus.busy, bus.done, bus.cmd_ready, bus.evt_count};
    total++;
    if (got !== 9'b00001_0000) $display("FAIL reset_async: got %b want %b", got, 9'b00001_0000);
    else passed++;
    repeat (2) @(negedge clk);
    got = {bus.psensor, bus.ssensor, bus.busy, bus.done, bus.cmd_ready, bus.evt_count};
    total++;
    if (got !== 9'b00001_0000) $display("FAIL reset_held: got %b want %b", got, 9'b00001_0000);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_exit;
    logic [4:0] got, exp;
    int h = 3;
    issue(1'b1, h);
    for (int k = 1; k <= 4 * h + 2; k++) begin
      @(negedge clk);
      exp = {exp_ps(1'b1, (k - 1) / h, (k - 1) % h), k == 4 * h + 1, k <= 4 * h + 1, k == 4 * h + 2};
      got = {bus.psensor, bus.ssensor, bus.done, bus.busy, bus.cmd_ready};
      total++;
      if (got !== exp) $display("FAIL exit_h3 cyc %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    total++;
    if (bus.evt_count !== 4'(exp_evt)) $display("FAIL exit_evt: got %0d want %0d", bus.evt_count, exp_evt);
    else passed++;
  endtask

  task automatic test_entry;
    logic [4:0] got, exp;
    int h = 5;
    issue(1'b0, h);
    bus.hold    = 20'd2;  // must be ignored: latched at accept
    bus.cmd_dir = 1'b1;
    for (int k = 1; k <= 4 * h + 2; k++) begin
      @(negedge clk);
      exp = {exp_ps(1'b0, (k - 1) / h, (k - 1) % h), k == 4 * h + 1, k <= 4 * h + 1, k == 4 * h + 2};
      got = {bus.psensor, bus.ssensor, bus.done, bus.busy, bus.cmd_ready};
      total++;
      if (got !== exp) $display("FAIL entry_h5 cyc %0d: got %b want %b", k, got, exp);
      else passed++;
      if (k == 1) begin
        total++;
        if (bus.evt_count !== 4'(exp_evt))
          $display("FAIL entry_evt_before: got %0d want %0d", bus.evt_count, exp_evt);
        else passed++;
      end
    end
    exp_evt++;
    total++;
    if (bus.evt_count !== 4'(exp_evt)) $display("FAIL entry_evt: got %0d want %0d", bus.evt_count, exp_evt);
    else passed++;
  endtask

  task automatic test_hold_zero;
    logic [4:0] got, exp;
    issue(1'b0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp = {exp_ps(1'b0, k - 1, 0), k == 5, k <= 5, k == 6};
      got = {bus.psensor, bus.ssensor, bus.done, bus.busy, bus.cmd_ready};
      total++;
      if (got !== exp) $display("FAIL hold0 cyc %0d: got %b want %b", k, got, exp);
      else passed++;
    end
    exp_evt++;
    total++;
    if (bus.evt_count !== 4'(exp_evt)) $display("FAIL hold0_evt: got %0d want %0d", bus.evt_count, exp_evt);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] got, exp;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.hold      = 20'd1;
    for (int p = 1; p <= 16; p++) begin
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        exp = {exp_ps(1'b0, k - 1, 0), k == 5, k <= 5, k == 6};
        got = {bus.psensor, bus.ssensor, bus.done, bus.busy, bus.cmd_ready};
        total++;
        if (got !== exp) $display("FAIL b2b run %0d cyc %0d: got %b want %b", p, k, got, exp);
        else passed++;
      end
      if (exp_evt < 15) exp_evt++;
      total++;
      if (bus.evt_count !== 4'(exp_evt))
        $display("FAIL b2b_evt run %0d: got %0d want %0d", p, bus.evt_count, exp_evt);
      else passed++;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [8:0] got;
    logic [1:0] ps;
    issue(1'b0, 5);
    repeat (7) @(negedge clk);
    ps = {bus.psensor, bus.ssensor};
    total++;
    if (ps !== 2'b11) $display("FAIL rmid_ph2: got %b want %b", ps, 2'b11);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    exp_evt = 0;
    got = {bus.psensor, bus.ssensor, bus.busy, bus.done, bus.cmd_ready, bus.evt_count};
    total++;
    if (got !== 9'b00001_0000) $display("FAIL rmid_abort: got %b want %b", got, 9'b00001_0000);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      got = {bus.psensor, bus.ssensor, bus.busy, bus.done, bus.cmd_ready, bus.evt_count};
      total++;
      if (got !== 9'b00001_0000) $display("FAIL rmid_idle cyc %0d: got %b want %b", k, got, 9'b00001_0000);
      else passed++;
    end
  endtask

`ifdef SENSOR_GEN_BOUNCE_EN
  task automatic test_bounce;
    logic [4:0] got, exp;
    int h = 40;
    issue(1'b0, h);
    for (int k = 1; k <= 4 * h + 2; k++) begin
      @(negedge clk);
      exp = {exp_ps(1'b0, (k - 1) / h, (k - 1) % h), k == 4 * h + 1, k <= 4 * h + 1, k == 4 * h + 2};
      got = {bus.psensor, bus.ssensor, bus.done, bus.busy, bus.cmd_ready};
      total++;
      if (got !== exp) $display("FAIL bounce cyc %0d: got %b want %b", k, got, exp);
      else passed++;
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.hold      = '0;
    test_reset();
    test_exit();
    test_entry();
    test_hold_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef SENSOR_GEN_BOUNCE_EN
    test_bounce();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
